// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - RV32I opcode constants, ALU op classes and control bundle type
package control_pkg;

  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_I     = 7'b0010011;
  localparam logic [6:0] OPCODE_L     = 7'b0000011;
  localparam logic [6:0] OPCODE_S     = 7'b0100011;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;

  localparam logic [2:0] ALU_OP_ADD    = 3'b000;
  localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
  localparam logic [2:0] ALU_OP_R      = 3'b010;
  localparam logic [2:0] ALU_OP_I      = 3'b011;
  localparam logic [2:0] ALU_OP_PASS_B = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       alu_data1;
    logic       mem_write;
    logic       mem_read;
    logic       men_to_reg;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// rtl/control_decode.sv - combinational opcode to control bundle decoder
import control_pkg::*;

module control_decode (
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  // Unknown opcodes fall through to an all-zero bundle flagged illegal
  always_comb begin
    ctrl         = '0;
    ctrl.illegal = 1'b1;
    case (opcode)
      OPCODE_R: begin
        ctrl.illegal   = 1'b0;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_R;
      end
      OPCODE_I: begin
        ctrl.illegal   = 1'b0;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_I;
        ctrl.alu_src   = 1'b1;
      end
      OPCODE_L: begin
        ctrl.illegal    = 1'b0;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.men_to_reg = 1'b1;
      end
      OPCODE_S: begin
        ctrl.illegal   = 1'b0;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OPCODE_B: begin
        ctrl.illegal = 1'b0;
        ctrl.alu_op  = ALU_OP_BRANCH;
        ctrl.branch  = 1'b1;
      end
      OPCODE_LUI: begin
        ctrl.illegal   = 1'b0;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_PASS_B;
        ctrl.alu_src   = 1'b1;
      end
      OPCODE_AUIPC: begin
        ctrl.illegal   = 1'b0;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_data1 = 1'b1;
      end
      OPCODE_JAL: begin
        ctrl.illegal   = 1'b0;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_data1 = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OPCODE_JALR: begin
        ctrl.illegal   = 1'b0;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.jump      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control.sv
// rtl/control.sv - registered RV32I main control unit
import control_pkg::*;

module control (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [6:0] opcode_i,
  output logic       reg_write_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_o,
  output logic       alu_data1_o,
  output logic       mem_write_o,
  output logic       mem_read_o,
  output logic       men_to_reg_o,
  output logic       branch_o,
  output logic       jump_o,
  output logic       illegal_o
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .opcode (opcode_i),
    .ctrl   (ctrl_d)
  );

  // Output register loads every cycle; reset clears everything including illegal
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ctrl_q <= '0;
    else          ctrl_q <= ctrl_d;
  end

  assign reg_write_o  = ctrl_q.reg_write;
  assign alu_op_o     = ctrl_q.alu_op;
  assign alu_src_o    = ctrl_q.alu_src;
  assign alu_data1_o  = ctrl_q.alu_data1;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_read_o   = ctrl_q.mem_read;
  assign men_to_reg_o = ctrl_q.men_to_reg;
  assign branch_o     = ctrl_q.branch;
  assign jump_o       = ctrl_q.jump;
  assign illegal_o    = ctrl_q.illegal;

endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - scoreboard bench for the registered control unit
module tb_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       reg_write, alu_src, alu_data1, mem_write, mem_read;
  logic       men_to_reg, branch, jump, illegal;
  logic [2:0] alu_op;
  logic [11:0] obs;

  int tests = 0;
  int fails = 0;
  int illegal_cnt = 0;
  logic [11:0] sb[$];

  control dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .opcode_i     (opcode),
    .reg_write_o  (reg_write),
    .alu_op_o     (alu_op),
    .alu_src_o    (alu_src),
    .alu_data1_o  (alu_data1),
    .mem_write_o  (mem_write),
    .mem_read_o   (mem_read),
    .men_to_reg_o (men_to_reg),
    .branch_o     (branch),
    .jump_o       (jump),
    .illegal_o    (illegal)
  );

  assign obs = {reg_write, alu_op, alu_src, alu_data1, mem_write,
                mem_read, men_to_reg, branch, jump, illegal};

  // Clock generator
  always #5 clk = ~clk;

  // Reference decode: {reg_write, alu_op, alu_src, alu_data1, mem_write, mem_read, men_to_reg, branch, jump, illegal}
  function automatic logic [11:0] ref_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 12'b1_010_0_0_0_0_0_0_0_0;
      7'b0010011: return 12'b1_011_1_0_0_0_0_0_0_0;
      7'b0000011: return 12'b1_000_1_0_0_1_1_0_0_0;
      7'b0100011: return 12'b0_000_1_0_1_0_0_0_0_0;
      7'b1100011: return 12'b0_001_0_0_0_0_0_1_0_0;
      7'b0110111: return 12'b1_100_1_0_0_0_0_0_0_0;
      7'b0010111: return 12'b1_000_1_1_0_0_0_0_0_0;
      7'b1101111: return 12'b1_000_1_1_0_0_0_0_1_0;
      7'b1100111: return 12'b1_000_1_0_0_0_0_0_1_0;
      default:    return 12'b0_000_0_0_0_0_0_0_0_1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [11:0] o, input logic [11:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic check_bit(input string tag, input logic o, input logic e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Drive on the falling edge, push expectation, compare 1 time unit after the rising edge
  task automatic step(input logic rst, input logic [6:0] op, input string tag);
    logic [11:0] e;
    @(negedge clk);
    rst_n  = rst;
    opcode = op;
    sb.push_back(rst ? ref_of(op) : 12'h000);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, obs, e);
  endtask

  initial begin
    logic [6:0] seq [7];
    logic [6:0] op;
    int onehot;
    seq = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111};
    rst_n  = 1'b0;
    opcode = 7'b0110011;

    // Reset held two cycles with an R opcode present
    step(1'b0, 7'b0110011, "reset_c0");
    step(1'b0, 7'b0110011, "reset_c1");
    check_bit("reset_illegal", illegal, 1'b0);

    // Back-to-back legal rows; first step after reset registers its opcode
    foreach (seq[i]) step(1'b1, seq[i], $sformatf("row_%b", seq[i]));

    // JAL then JALR
    step(1'b1, 7'b1101111, "jal_row");
    check_bit("jal_jump", jump, 1'b1);
    check_bit("jal_data1", alu_data1, 1'b1);
    step(1'b1, 7'b1100111, "jalr_row");
    check_bit("jalr_jump", jump, 1'b1);
    check_bit("jalr_data1", alu_data1, 1'b0);
    check_bit("jalr_regwr", reg_write, 1'b1);

    // Illegal extremes
    step(1'b1, 7'b0000000, "illegal_00");
    step(1'b1, 7'b1111111, "illegal_7f");

    // Reset pulse while streaming LOAD
    step(1'b1, 7'b0000011, "load_pre");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("no_async_reset", obs, ref_of(7'b0000011));
    sb.push_back(12'h000);
    @(posedge clk);
    #1;
    check("load_reset", obs, sb.pop_front());
    step(1'b1, 7'b0000011, "load_resume");
    check_bit("load_mem_read", mem_read, 1'b1);
    check_bit("load_m2r", men_to_reg, 1'b1);
    step(1'b1, 7'b0000011, "load_resume2");

    // Exhaustive sweep with structural invariants
    for (int k = 0; k < 128; k++) begin
      op = 7'(k);
      step(1'b1, op, $sformatf("sweep_%b", op));
      onehot = int'(mem_write) + int'(mem_read) + int'(branch) + int'(jump);
      check_bit($sformatf("excl_%b", op), onehot <= 1, 1'b1);
      check_bit($sformatf("m2r_%b", op), men_to_reg & ~mem_read, 1'b0);
      if (illegal === 1'b1) illegal_cnt++;
    end
    tests++;
    assert (illegal_cnt == 119) else begin
      fails++;
      $error("FAIL illegal_count observed=%0d expected=119", illegal_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
